// File: rtl/hazard_forward_ctrl_if.sv
// hazard_forward_ctrl_if: decode-stage register fields in, forwarding selects and stall/bubble controls out.
interface hazard_forward_ctrl_if;
  logic [4:0] RnIn;
  logic [4:0] RmIn;
  logic [4:0] RdIn;
  logic       UsesA;
  logic       UsesB;
  logic       RegWriteIn;
  logic       Mem2RegIn;
  logic       Flush;
  logic [1:0] ForwardMuxA;
  logic [1:0] ForwardMuxB;
  logic       Stall;
  logic       Bubble;
  modport master (
    output RnIn, RmIn, RdIn, UsesA, UsesB, RegWriteIn, Mem2RegIn, Flush,
    input  ForwardMuxA, ForwardMuxB, Stall, Bubble
  );
  modport slave (
    input  RnIn, RmIn, RdIn, UsesA, UsesB, RegWriteIn, Mem2RegIn, Flush,
    output ForwardMuxA, ForwardMuxB, Stall, Bubble
  );
endinterface

// File: rtl/hazard_forward_ctrl.sv
// hazard_forward_ctrl: REG/DEC forwarding selects and load-use stall sequencing for the 5-stage pipeline.
// Define HAZARD_PERF_CNT_EN to add the saturating StallCount bubble counter output.
module hazard_forward_ctrl #(
  parameter int         LOAD_STALL_CYCLES = 1,
  parameter logic [4:0] ZERO_REG          = 5'd31
) (
  input  logic        clk,
  input  logic        reset,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0] StallCount,
`endif
  hazard_forward_ctrl_if.slave bus
);
  typedef enum logic {IDLE, STALL} state_t;
  localparam logic [1:0] CNT_LAST = 2'(LOAD_STALL_CYCLES - 1);
  state_t     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [4:0] ex_rd_q, mem_rd_q;
  logic       ex_wr_q, ex_ld_q, mem_wr_q;
  logic       ex_a, ex_b, mem_a, mem_b, hazard, stall, kill;
  assign ex_a   = bus.UsesA && ex_wr_q && ex_rd_q == bus.RnIn && bus.RnIn != ZERO_REG;
  assign ex_b   = bus.UsesB && ex_wr_q && ex_rd_q == bus.RmIn && bus.RmIn != ZERO_REG;
  assign mem_a  = bus.UsesA && mem_wr_q && mem_rd_q == bus.RnIn && bus.RnIn != ZERO_REG;
  assign mem_b  = bus.UsesB && mem_wr_q && mem_rd_q == bus.RmIn && bus.RmIn != ZERO_REG;
  assign hazard = (ex_a || ex_b) && ex_ld_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    if (state_q == STALL) begin
      stall   = 1'b1;
      cnt_d   = bus.Flush ? 2'd0 : cnt_q - 2'd1;
      state_d = (bus.Flush || cnt_q <= 2'd1) ? IDLE : STALL;
    end else if (hazard && !bus.Flush) begin
      stall   = 1'b1;
      cnt_d   = CNT_LAST;
      state_d = CNT_LAST != 2'd0 ? STALL : IDLE;
    end
  end
  // A load sitting in EX has no result yet, and an older MEM copy would be stale.
  assign bus.ForwardMuxA = stall ? 2'b00 : ex_a ? (ex_ld_q ? 2'b00 : 2'b01) : mem_a ? 2'b10 : 2'b00;
  assign bus.ForwardMuxB = stall ? 2'b00 : ex_b ? (ex_ld_q ? 2'b00 : 2'b01) : mem_b ? 2'b10 : 2'b00;
  assign bus.Stall       = stall;
  assign bus.Bubble      = stall;
  assign kill            = stall || bus.Flush;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 2'd0;
      ex_rd_q  <= 5'd0;
      ex_wr_q  <= 1'b0;
      ex_ld_q  <= 1'b0;
      mem_rd_q <= 5'd0;
      mem_wr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mem_rd_q <= ex_rd_q;
      mem_wr_q <= ex_wr_q;
      ex_rd_q  <= bus.RdIn;
      ex_wr_q  <= bus.RegWriteIn && !kill;
      ex_ld_q  <= bus.Mem2RegIn && !kill;
    end
  end
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  always_ff @(posedge clk) begin
    if (reset) stall_cnt_q <= 32'd0;
    else if (stall && stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_q <= stall_cnt_q + 32'd1;
  end
  assign StallCount = stall_cnt_q;
`endif
endmodule
